// File: rtl/thermometer_codec_top.sv
// ---------------------------------------------------------------------------
// thermometer_codec_top
//   Round-trip binary <-> thermometer codec used for board bring-up.
//   The K-bit switch value is encoded into a W-bit thermometer word
//   (registered and exported), then decoded back to K bits. sel chooses
//   whether the LEDs show the decoded round trip or the raw switch value;
//   both paths have the same 2-cycle latency so toggling sel never skews data.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset (clears every register)
//   sw     in   K  binary input value
//   sel    in   1  1 = LEDs show decoded round trip, 0 = delayed sw
//   therm  out  W  registered thermometer code of sw
//   led    out  K  registered output value
// ---------------------------------------------------------------------------
module thermometer_codec_top #(
    parameter int K = 7,
    parameter int W = 2**K - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] sw,
    input  logic         sel,
    output logic [W-1:0] therm,
    output logic [K-1:0] led
);

    // The decoder relies on W = 2**K-1 so that highest-index+1 fits in K bits.
    generate
        if (W != 2**K - 1) begin : g_bad_width
            $error("thermometer_codec_top: W (%0d) must equal 2**K-1 (%0d)", W, 2**K - 1);
        end
    endgenerate

    // Bit i is set when i < v; comparison stays 4-state so X on sw propagates.
    function automatic logic [W-1:0] therm_enc(input logic [K-1:0] v);
        logic [W-1:0] t;
        for (int i = 0; i < W; i++) begin
            t[i] = (K'(i) < v);
        end
        return t;
    endfunction

    // Highest set bit index plus one; bubbles are ignored below the top bit.
    function automatic logic [K-1:0] therm_dec(input logic [W-1:0] t);
        logic [K-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (t[i]) begin
                r = K'(i + 1);
            end
        end
        return r;
    endfunction

    logic [W-1:0] therm_p1;
    logic [K-1:0] sw_p1;
    logic [K-1:0] led_p2;

    // ---- stage 1: encode, delay raw switch value alongside ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            therm_p1 <= '0;
            sw_p1    <= '0;
        end else begin
            therm_p1 <= therm_enc(sw);
            sw_p1    <= sw;
        end
    end

    // ---- stage 2: decode or pass delayed switch, sel sampled here only ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_p2 <= '0;
        end else begin
            led_p2 <= sel ? therm_dec(therm_p1) : sw_p1;
        end
    end

    assign therm = therm_p1;
    assign led   = led_p2;

endmodule

// File: tb/tb_thermometer_codec_top.sv
// ---------------------------------------------------------------------------
// tb_thermometer_codec_top
//   Directed and randomized stimulus for thermometer_codec_top, compared
//   against a cycle-level reference model built from arithmetic
//   ((1<<n)-1 for encoding, population count for decoding a clean word).
// ---------------------------------------------------------------------------
module tb_thermometer_codec_top;

    localparam int K = 7;
    localparam int W = 2**K - 1;

    logic         clk;
    logic         rst_n;
    logic [K-1:0] sw;
    logic         sel;
    logic [W-1:0] therm;
    logic [K-1:0] led;

    thermometer_codec_top #(.K(K), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .sel   (sel),
        .therm (therm),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [W-1:0] m_therm;
    logic [K-1:0] m_swd;
    logic [K-1:0] m_led;

    function automatic logic [W-1:0] thermo(input int n);
        logic [127:0] v;
        v = (128'd1 << n) - 128'd1;
        return v[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_therm = '0;
        m_swd   = '0;
        m_led   = '0;
    endtask

    // Advance one rising edge, update the model with the inputs present at
    // that edge, then settle 1 time unit past the edge.
    task automatic step();
        logic [K-1:0] s;
        logic         sl;
        s  = sw;
        sl = sel;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            m_led   = sl ? K'($countones(m_therm)) : m_swd;
            m_therm = thermo(int'(s));
            m_swd   = s;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".therm"}, therm, m_therm);
        chk({tag, ".led"}, W'(led), W'(m_led));
    endtask

    logic [W-1:0] bubble;

    initial begin
        rst_n = 1'b0;
        sw    = 7'h55;
        sel   = 1'b0;
        model_clear();

        // 1: held in reset while clocking
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.therm", therm, '0);
            chk("rst.led", W'(led), '0);
        end
        rst_n = 1'b1;
        step();
        check_all("rel1");
        step();
        check_all("rel2");
        chk("rel.led55", W'(led), W'(7'h55));

        // 2: sw=0 decoded
        sel = 1'b1;
        sw  = 7'd0;
        step();
        chk("zero.therm", therm, '0);
        step();
        chk("zero.led", W'(led), '0);

        // 3: sw=5 then sw=127
        sw = 7'd5;
        step();
        chk("five.therm", therm, W'(127'h1F));
        step();
        chk("five.led", W'(led), W'(7'd5));
        sw = 7'd127;
        step();
        chk("max.therm", therm, {W{1'b1}});
        step();
        chk("max.led", W'(led), W'(7'd127));

        // 4: raw path, back-to-back values
        sel = 1'b0;
        sw = 7'd3;  step(); check_all("seq3");
        sw = 7'd64; step(); check_all("seq64");
        sw = 7'd1;  step(); check_all("seq1");
        step(); check_all("seq_tail1");
        step(); check_all("seq_tail2");

        // 5: hold 42, toggle sel every cycle
        sw = 7'd42;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            sel = ~sel;
            step();
            chk("hold42.led", W'(led), W'(7'd42));
        end

        // bubble word 0..0100 must decode to 3
        bubble = W'(3'b100);
        sel = 1'b1;
        force dut.therm_p1 = bubble;
        step();
        release dut.therm_p1;
        m_led = 7'd3;
        chk("bubble.led", W'(led), W'(7'd3));
        sel = 1'b0;
        step();
        check_all("post_bubble");

        // 6: asynchronous reset between edges
        sw  = 7'd100;
        sel = 1'b1;
        step();
        step();
        check_all("pre_arst");
        #2 rst_n = 1'b0;
        #1;
        chk("arst.therm", therm, '0);
        chk("arst.led", W'(led), '0);
        model_clear();
        step();
        rst_n = 1'b1;
        step();
        check_all("arst_rel1");
        step();
        check_all("arst_rel2");
        chk("arst.led100", W'(led), W'(7'd100));

        // randomized stream
        for (int i = 0; i < 200; i++) begin
            sw  = K'($urandom_range(0, 2**K - 1));
            sel = 1'($urandom_range(0, 1));
            step();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
